// File: rtl/sdpram_if.sv
// sdpram_if
// Signal bundle for the simple dual-port RAM.
//   addra / wena / dina : write port A (address, lane enables, data)
//   addrb / renb        : read port B request (address, enable)
//   doutb / dvalb       : read port B response (registered data, valid pulse)
// Modports:
//   sdp_s : RAM side (consumes port A and B requests, drives the response)
//   sdp_m : client side (drives requests, observes the response)
interface sdpram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int STRB_WIDTH = 1
);

  logic [ADDR_WIDTH-1:0] addra;
  logic [STRB_WIDTH-1:0] wena;
  logic [DATA_WIDTH-1:0] dina;
  logic [ADDR_WIDTH-1:0] addrb;
  logic                  renb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  dvalb;

  modport sdp_s (
    input  addra,
    input  wena,
    input  dina,
    input  addrb,
    input  renb,
    output doutb,
    output dvalb
  );

  modport sdp_m (
    output addra,
    output wena,
    output dina,
    output addrb,
    output renb,
    input  doutb,
    input  dvalb
  );

endinterface

// File: rtl/simple_dual_port_ram.sv
// simple_dual_port_ram
// Generic on-chip buffer: one write-only port (A) and one read-only port (B)
// sharing a single clock. Port A optionally writes individual byte lanes;
// port B returns registered data one cycle after the request together with
// a one-cycle valid pulse.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset (clears the read response only,
//         never the storage array)
//   ifp : sdpram_if.sdp_s carrying addra/wena/dina, addrb/renb, doutb/dvalb
module simple_dual_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int BYTE_WRITE = 0
) (
  input logic    clk,
  input logic    rst,
  sdpram_if.sdp_s ifp
);

  // A depth of one still needs a one-bit address bus to keep the port legal.
  localparam int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int STRB_WIDTH = (BYTE_WRITE != 0) ? DATA_WIDTH / 8 : 1;
  // With a single enable the one "lane" is the full word, so the same write
  // loop serves both byte-write and word-write builds.
  localparam int LANE_WIDTH = DATA_WIDTH / STRB_WIDTH;

  // One extra bit lets the depth itself be represented for the range check.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic wr_in_range;
  logic rd_in_range;

  // Addresses past the end only exist when the depth is not a power of two;
  // for power-of-two depths these compare to constant true and vanish.
  assign wr_in_range = ({1'b0, ifp.addra} < DEPTH_LIMIT);
  assign rd_in_range = ({1'b0, ifp.addrb} < DEPTH_LIMIT);

  // Storage has no reset so it can map onto block RAM. Writes are blocked
  // while rst is high, and out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_in_range) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (ifp.wena[i]) begin
          mem[ifp.addra][i*LANE_WIDTH +: LANE_WIDTH] <= ifp.dina[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // The read register samples the array with a non-blocking read in the
  // same edge as the write, so a same-address access returns the old word
  // (read-first). Out-of-range reads still complete, returning zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifp.doutb <= '0;
      ifp.dvalb <= 1'b0;
    end else if (ifp.renb) begin
      ifp.doutb <= rd_in_range ? mem[ifp.addrb] : '0;
      ifp.dvalb <= 1'b1;
    end else begin
      ifp.dvalb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// tb_simple_dual_port_ram
// Drives the RAM (byte-write build, 32-bit x 1024) with directed sequences
// and then random traffic, comparing every cycle against a word-array model.
module tb_simple_dual_port_ram;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int SW    = 4;

  logic clk;
  logic rst;

  sdpram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

  simple_dual_port_ram #(
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH),
    .BYTE_WRITE(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ifp(bus)
  );

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  // Reference: contents as a plain array, plus the response the outputs
  // must show after the most recent edge.
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] expDout;
  logic          expDval;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Each edge: a read sees the array as it was before this edge's write,
  // then the enabled byte lanes of the write land. Reset wipes the response
  // at once and lets nothing through.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expDout = '0;
      expDval = 1'b0;
    end else begin
      expDval = bus.renb;
      if (bus.renb) expDout = model[bus.addrb];
      for (int i = 0; i < SW; i++)
        if (bus.wena[i]) model[bus.addra][8*i +: 8] = bus.dina[8*i +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: mid-cycle, outputs must match the model exactly
  // (doutb holds its value across idle cycles too).
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("dvalb", {31'b0, bus.dvalb}, {31'b0, expDval});
      checkOutput("doutb", bus.doutb, expDout);
    end
  end

  // Present one cycle of inputs, then return just after the edge that
  // consumed them.
  task automatic applyStimulus(input logic r, input logic [SW-1:0] we,
                               input logic [AW-1:0] aa, input logic [DW-1:0] da,
                               input logic re, input logic [AW-1:0] ab);
    rst      = r;
    bus.wena = we;
    bus.addra = aa;
    bus.dina = da;
    bus.renb = re;
    bus.addrb = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    applyStimulus(r, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    rst = 1'b0;
    bus.wena = '0; bus.addra = '0; bus.dina = '0;
    bus.renb = 1'b0; bus.addrb = '0;

    // Reset takes hold before any clock edge.
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_async_doutb", bus.doutb, 32'h0);
    checkOutput("rst_async_dvalb", {31'b0, bus.dvalb}, 32'h0);
    checking = 1;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      checkOutput("rst_idle_doutb", bus.doutb, 32'h0);
      checkOutput("rst_idle_dvalb", {31'b0, bus.dvalb}, 32'h0);
    end

    // Fill the whole array so every later read has a defined answer.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 4'hF, AW'(i), $urandom, 1'b0, '0);

    // Write then read.
    applyStimulus(1'b0, 4'hF, 10'h001, 32'h0000_0055, 1'b0, '0);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 10'h001);
    checkOutput("wr_rd_doutb", bus.doutb, 32'h0000_0055);
    checkOutput("wr_rd_dvalb", {31'b0, bus.dvalb}, 32'h1);

    // Same-address read and write: old word first, new word afterwards.
    idle(1'b1);
    idle(1'b1);
    applyStimulus(1'b0, 4'hF, 10'h001, 32'hAAAA_AAAA, 1'b0, '0);
    applyStimulus(1'b0, 4'hF, 10'h001, 32'h0000_0055, 1'b1, 10'h001);
    checkOutput("rf_first", bus.doutb, 32'hAAAA_AAAA);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'hF, 10'h001, 32'h0000_0055, 1'b1, 10'h001);
      checkOutput("rf_later", bus.doutb, 32'h0000_0055);
    end

    // Streaming.
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, 4'hF, AW'(i), i * 32'h0101_0101, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, AW'(i));
      checkOutput("stream_data", bus.doutb, i * 32'h0101_0101);
      checkOutput("stream_dvalb", {31'b0, bus.dvalb}, 32'h1);
    end
    idle(1'b0);
    checkOutput("stream_drop_dvalb", {31'b0, bus.dvalb}, 32'h0);
    checkOutput("stream_hold_doutb", bus.doutb, 32'h0F0F_0F0F);

    // Byte lanes at the top address.
    applyStimulus(1'b0, 4'hF, 10'h3FF, 32'h1122_3344, 1'b0, '0);
    applyStimulus(1'b0, 4'b0101, 10'h3FF, 32'hAABB_CCDD, 1'b0, '0);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 10'h3FF);
    checkOutput("byte_write", bus.doutb, 32'h11BB_33DD);

    // Reset in the same cycle as a read and a write to 0x010.
    applyStimulus(1'b0, 4'hF, 10'h010, 32'h0, 1'b0, '0);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 10'h3FF);
    checkOutput("pre_rst_dvalb", {31'b0, bus.dvalb}, 32'h1);
    rst = 1'b1;
    bus.wena = 4'hF; bus.addra = 10'h010; bus.dina = 32'hDEAD_BEEF;
    bus.renb = 1'b1; bus.addrb = 10'h010;
    #1;
    checkOutput("midrst_async_dvalb", {31'b0, bus.dvalb}, 32'h0);
    checkOutput("midrst_async_doutb", bus.doutb, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("midrst_edge_dvalb", {31'b0, bus.dvalb}, 32'h0);
    checkOutput("midrst_edge_doutb", bus.doutb, 32'h0);
    idle(1'b0);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, 10'h010);
    checkOutput("midrst_no_write", bus.doutb, 32'h0);
    checkOutput("midrst_rd_dvalb", {31'b0, bus.dvalb}, 32'h1);

    // Random traffic, biased toward a few addresses so collisions happen.
    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      b = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      applyStimulus(($urandom_range(0, 199) == 0), SW'($urandom), a, $urandom,
                    ($urandom_range(0, 3) != 0), b);
    end
    idle(1'b0);
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
